// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by the transmitter and the receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package serial_pkg;

  localparam int DATA_W          = 7;
  localparam int FRAME_DATA_BITS = 8;  // 7 payload bits + parity

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Even parity over the frame: XOR of the payload bits, so that the
  // XOR of all eight post-start bits is 0 for a good frame.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Small synchronous FIFO that queues payload words ahead of the serialiser.
// Latency: a pushed word is visible on pop_dat / empty=0 the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; caller gates on full/empty.
module serial_tx_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array: written on push, no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// Serialises 7-bit words as start, LSB-first data, even parity, STOP_BITS stop bits.
// Latency: start bit one cycle after acceptance (two with TRANSMITTER_FIFO_EN).
// Backpressure: ready_out low mid-frame (no FIFO) or when the FIFO is full (TRANSMITTER_FIFO_EN).
module transmitter
  import serial_pkg::*;
#(
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              serial_out,
  output logic              busy
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 4 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("transmitter: STOP_BITS must be 1..4 and FIFO_DEPTH a power of two >= 2");
  end

  tx_state_t         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q;
  logic              par_q;
  logic              serial_d;
  logic              frame_end;
  logic              can_start;
  logic              load;
  logic [DATA_W-1:0] load_dat;
  logic              pending;

  // A new frame may begin from IDLE or directly out of the last stop cycle.
  assign frame_end = (state_q == TX_STOP) && (cnt_q == LAST_STOP);
  assign can_start = (state_q == TX_IDLE) || frame_end;

`ifdef TRANSMITTER_FIFO_EN
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dat;

  // Acceptance only depends on FIFO space; the FSM drains the head when free.
  assign ready_out = rstn & ~fifo_full;
  assign push      = valid_in & ready_out;
  assign load      = rstn & can_start & ~fifo_empty;
  assign load_dat  = fifo_dat;
  assign pending   = ~fifo_empty;

  serial_tx_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .push_dat(data_in),
    .pop     (load),
    .pop_dat (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  // Direct handoff: the word is taken straight into the frame registers.
  assign ready_out = rstn & can_start;
  assign load      = valid_in & ready_out;
  assign load_dat  = data_in;
  assign pending   = 1'b0;
`endif

  assign busy = (state_q != TX_IDLE) || pending;

  // Next-state sequencing, and the line level for the state being entered so
  // that the registered serial_out lines up with state_q.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    serial_d = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (load) state_d = TX_START;
      end
      TX_START: begin
        state_d = TX_DATA;
        cnt_d   = '0;
      end
      TX_DATA: begin
        if (cnt_q == LAST_DATA) begin
          state_d = TX_PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        state_d = TX_STOP;
        cnt_d   = '0;
      end
      TX_STOP: begin
        if (cnt_q == LAST_STOP) begin
          cnt_d   = '0;
          state_d = load ? TX_START : TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
    case (state_d)
      TX_START:  serial_d = 1'b0;
      TX_DATA:   serial_d = dat_q[cnt_d];
      TX_PARITY: serial_d = par_q;
      default:   serial_d = 1'b1;
    endcase
  end

  // State, counter, line register and the latched word; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      serial_out <= 1'b1;
      dat_q      <= '0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      serial_out <= serial_d;
      if (load) begin
        dat_q <= load_dat;
        par_q <= calc_parity(load_dat);
      end
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: vector table, corner sequences, loopback scoreboard.
// Latency: expects start bit 1 cycle after acceptance (2 with TRANSMITTER_FIFO_EN).
// Backpressure: stimulus holds valid_in until ready_out is seen high.
`timescale 1ns/1ps
module tb_transmitter;
  import serial_pkg::*;

  localparam int STOP_BITS = 1;
`ifdef TRANSMITTER_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [DATA_W-1:0] dat;
    logic [0:9]        bits;  // line levels in transmission order
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ready_out;
  logic              serial_out;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_frames = 0;
  int rx_frames = 0;
  logic [DATA_W-1:0] exp_q[$];

  transmitter #(
    .STOP_BITS (STOP_BITS),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .serial_out(serial_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Line decoder acting as the receiver: decodes frames, checks stop and
  // parity, and compares payloads in order against the scoreboard queue.
  always begin : rx_monitor
    logic [DATA_W-1:0] d;
    logic p;
    logic stop_ok;
    logic aborted;
    @(negedge clk);
    if (rstn === 1'b1 && serial_out === 1'b0) begin
      aborted = 1'b0;
      stop_ok = 1'b1;
      d = '0;
      for (int i = 0; i < DATA_W; i++) begin
        @(negedge clk);
        d[i] = serial_out;
        if (rstn !== 1'b1) aborted = 1'b1;
      end
      @(negedge clk);
      p = serial_out;
      if (rstn !== 1'b1) aborted = 1'b1;
      for (int i = 0; i < STOP_BITS; i++) begin
        @(negedge clk);
        if (serial_out !== 1'b1) stop_ok = 1'b0;
        if (rstn !== 1'b1) aborted = 1'b1;
      end
      if (!aborted) begin
        rx_frames++;
        check("rx_stop_bits", 32'(stop_ok), 32'd1);
        check("rx_parity_ok_n", 32'(^{p, d}), 32'd0);
        check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check($sformatf("rx_data_%0d", rx_frames), 32'(d), 32'(exp_q.pop_front()));
      end
    end
  end

  // Offer a word and hold valid_in until it is taken; valid_in stays high afterwards.
  task automatic offer(input logic [DATA_W-1:0] d, input bit expect_it);
    int n;
    n = 0;
    valid_in = 1'b1;
    data_in  = d;
    @(negedge clk);
    while (ready_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 100), 32'd1);
    if (expect_it) begin
      exp_q.push_back(d);
      tx_frames++;
    end
    @(posedge clk);
    #1;
  endtask

  // Single word; data_in is scrambled after acceptance to prove it was latched.
  task automatic send(input logic [DATA_W-1:0] d, input bit expect_it);
    offer(d, expect_it);
    valid_in = 1'b0;
    data_in  = DATA_W'($urandom);
  endtask

  // Record the line for n cycles starting with the expected start-bit cycle.
  task automatic capture(input int n, output logic [0:19] b);
    b = '1;
    repeat (LAT - 1) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b[i] = serial_out;
    end
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[6];
    logic [0:19] got;
    logic [0:19] exp20;
    int          lows;
    int          n;

    vecs[0] = '{7'h55, 10'b0101010101};
    vecs[1] = '{7'h01, 10'b0100000011};
    vecs[2] = '{7'h7F, 10'b0111111111};
    vecs[3] = '{7'h00, 10'b0000000001};
    vecs[4] = '{7'h2A, 10'b0010101011};
    vecs[5] = '{7'h40, 10'b0000000111};

    // Reset held 3 cycles with valid_in asserted: nothing may be accepted.
    rstn     = 1'b0;
    valid_in = 1'b1;
    data_in  = 7'h33;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_serial_out", 32'(serial_out), 32'd1);
    check("rst_ready_out", 32'(ready_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    valid_in = 1'b0;
    rstn     = 1'b1;
    @(negedge clk);
    check("rel_serial_out", 32'(serial_out), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_ready_out", 32'(ready_out), 32'd1);
    @(posedge clk);
    #1;

    // Table of single frames: exact line pattern, then idle.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].dat, 1'b1);
      capture(10, got);
      check($sformatf("frame_%02h", vecs[v].dat), 32'(got[0:9]), 32'(vecs[v].bits));
      @(negedge clk);
      check($sformatf("idle_busy_%02h", vecs[v].dat), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end

    // Back-to-back with valid_in held: starts 10 cycles apart, one stop between.
    exp20 = {10'b0111111111, 10'b0000000001};
    offer(7'h7F, 1'b1);
    fork
      begin
        offer(7'h00, 1'b1);
        valid_in = 1'b0;
      end
      capture(20, got);
    join
    check("b2b_7f_00", 32'(got), 32'(exp20));
    repeat (3) @(posedge clk);
    #1;

    // Reset during data bit 3 of 7'h2A aborts the frame for good.
    send(7'h2A, 1'b0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_bit3_level", 32'(serial_out), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_serial_out", 32'(serial_out), 32'd1);
    check("abort_ready_out", 32'(ready_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (serial_out !== 1'b1) lows++;
    end
    check("abort_no_retransmit", 32'(lows), 32'd0);
    @(posedge clk);
    #1;

    // Loopback of all 128 values in 6-word bursts.
    for (int b = 0; b < 128; b += 6) begin
      for (int k = 0; k < 6 && (b + k) < 128; k++) offer(DATA_W'(b + k), 1'b1);
      valid_in = 1'b0;
      data_in  = DATA_W'($urandom);
      repeat (3) @(posedge clk);
      #1;
    end

    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (STOP_BITS + 2) @(negedge clk);
    check("drain_timeout", 32'(n < 2000), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(rx_frames), 32'(tx_frames));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
